// File: rtl/irq_ctrl.sv
// Nesting priority interrupt controller: edge-detected pending bits, per-source
// enable/priority, a registered highest-priority offer and a saved-priority stack.
module irq_ctrl #(
  parameter int NumIrq     = 8,
  parameter int PrioWidth  = 3,
  parameter int StackDepth = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NumIrq-1:0]         irq_in,
  output logic [NumIrq-1:0]         irq_clear,
  input  logic                      cfg_we,
  input  logic [$clog2(NumIrq)-1:0] cfg_idx,
  input  logic                      cfg_enable,
  input  logic [PrioWidth-1:0]      cfg_prio,
  output logic                      req_valid,
  output logic [$clog2(NumIrq)-1:0] req_id,
  output logic [PrioWidth-1:0]      req_prio,
  input  logic                      take,
  input  logic                      done,
  output logic [PrioWidth-1:0]      run_prio
);

  localparam int IdW    = $clog2(NumIrq);
  localparam int DepthW = $clog2(StackDepth + 1);
  localparam int SlotW  = (StackDepth > 1) ? $clog2(StackDepth) : 1;

  logic [NumIrq-1:0]    irq_p0;
  logic [NumIrq-1:0]    irq_p1;
  logic [NumIrq-1:0]    pending;
  logic [NumIrq-1:0]    enable;
  logic [PrioWidth-1:0] prio [NumIrq];
  logic [PrioWidth-1:0] stack [StackDepth];
  logic [DepthW-1:0]    depth;

  logic [NumIrq-1:0]    rise;
  logic [NumIrq-1:0]    clr_mask;
  logic                 take_eff;
  logic                 full;
  logic                 best_found;
  logic [IdW-1:0]       best_id;
  logic [PrioWidth-1:0] best_prio;
  logic [SlotW-1:0]     push_slot;
  logic [SlotW-1:0]     pop_slot;

  assign rise      = irq_p0 & ~irq_p1;
  assign take_eff  = take & req_valid;
  assign clr_mask  = take_eff ? (NumIrq'(1) << req_id) : '0;
  assign full      = (depth == DepthW'(StackDepth));
  assign push_slot = SlotW'(depth);
  assign pop_slot  = SlotW'(depth - DepthW'(1));

  // Arbitration: strict '>' against the running best keeps the lowest index on ties.
  always_comb begin
    best_found = 1'b0;
    best_id    = '0;
    best_prio  = '0;
    for (int i = 0; i < NumIrq; i++) begin
      if (pending[i] && enable[i] && (prio[i] != '0) && (prio[i] > run_prio) &&
          (prio[i] > best_prio)) begin
        best_found = 1'b1;
        best_id    = IdW'(i);
        best_prio  = prio[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_p0    <= '0;
      irq_p1    <= '0;
      pending   <= '0;
      enable    <= '0;
      depth     <= '0;
      run_prio  <= '0;
      req_valid <= 1'b0;
      req_id    <= '0;
      req_prio  <= '0;
      irq_clear <= '0;
      for (int i = 0; i < NumIrq; i++) prio[i] <= '0;
      for (int i = 0; i < StackDepth; i++) stack[i] <= '0;
    end else begin
      // Stage p0 samples the lines, p1 holds the previous sample for edge detection.
      irq_p0  <= irq_in;
      irq_p1  <= irq_p0;
      // A new edge landing on the take cycle must survive the clear.
      pending <= (pending & ~clr_mask) | rise;

      if (cfg_we && (int'(cfg_idx) < NumIrq)) begin
        enable[cfg_idx] <= cfg_enable;
        prio[cfg_idx]   <= cfg_prio;
      end

      // Offer stage: suppressed on the take cycle and while the stack is full.
      req_valid <= best_found && !full && !take_eff;
      req_id    <= best_id;
      req_prio  <= best_prio;
      irq_clear <= clr_mask;

      if (take_eff && done) begin
        run_prio <= req_prio;
      end else if (take_eff) begin
        stack[push_slot] <= run_prio;
        depth            <= depth + DepthW'(1);
        run_prio         <= req_prio;
      end else if (done && (depth != '0)) begin
        run_prio <= stack[pop_slot];
        depth    <= depth - DepthW'(1);
      end
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: each task drives one scenario and checks inline
// against hand-computed cycle-by-cycle expectations.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_in;
  logic [7:0] irq_clear;
  logic       cfg_we;
  logic [2:0] cfg_idx;
  logic       cfg_enable;
  logic [2:0] cfg_prio;
  logic       req_valid;
  logic [2:0] req_id;
  logic [2:0] req_prio;
  logic       take;
  logic       done;
  logic [2:0] run_prio;

  int total = 0;
  int bad   = 0;

  irq_ctrl #(.NumIrq(8), .PrioWidth(3), .StackDepth(4)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .irq_clear(irq_clear),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_enable(cfg_enable), .cfg_prio(cfg_prio),
    .req_valid(req_valid), .req_id(req_id), .req_prio(req_prio),
    .take(take), .done(done), .run_prio(run_prio)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; irq_in = '0; take = 1'b0; done = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_enable = 1'b0; cfg_prio = '0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic cfg(input int idx, input bit en, input int p);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_enable = en; cfg_prio = 3'(p);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", req_valid); end
    total++; if (req_id !== 3'd0) begin bad++; $display("FAIL rst_id got=%0d want=0", req_id); end
    total++; if (req_prio !== 3'd0) begin bad++; $display("FAIL rst_prio got=%0d want=0", req_prio); end
    total++; if (run_prio !== 3'd0) begin bad++; $display("FAIL rst_run got=%0d want=0", run_prio); end
    total++; if (irq_clear !== 8'h00) begin bad++; $display("FAIL rst_clear got=%h want=00", irq_clear); end
  endtask

  task automatic test_basic();
    do_reset();
    cfg(2, 1'b1, 3);
    irq_in[2] = 1'b1;
    step();
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL basic_n got=%0b want=0", req_valid); end
    step();
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL basic_n1 got=%0b want=0", req_valid); end
    step();
    total++; if ({req_valid, req_id, req_prio} !== {1'b1, 3'd2, 3'd3}) begin bad++;
      $display("FAIL basic_offer got=%0b/%0d/%0d want=1/2/3", req_valid, req_id, req_prio); end
    take = 1'b1;
    step();
    take = 1'b0;
    total++; if (run_prio !== 3'd3) begin bad++; $display("FAIL basic_run got=%0d want=3", run_prio); end
    total++; if (irq_clear !== 8'h04) begin bad++; $display("FAIL basic_clear got=%h want=04", irq_clear); end
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL basic_b2b got=%0b want=0", req_valid); end
    step();
    total++; if (irq_clear !== 8'h00) begin bad++; $display("FAIL basic_pulse got=%h want=00", irq_clear); end
    done = 1'b1;
    step();
    done = 1'b0;
    total++; if (run_prio !== 3'd0) begin bad++; $display("FAIL basic_done got=%0d want=0", run_prio); end
    // Nothing to pop now: run_prio must stay at thread level.
    done = 1'b1;
    step();
    done = 1'b0;
    total++; if (run_prio !== 3'd0) begin bad++; $display("FAIL basic_empty_done got=%0d want=0", run_prio); end
  endtask

  task automatic test_priority();
    do_reset();
    cfg(1, 1'b1, 2); cfg(5, 1'b1, 2); cfg(4, 1'b1, 5);
    irq_in = 8'b0011_0010;
    step(3);
    total++; if ({req_valid, req_id, req_prio} !== {1'b1, 3'd4, 3'd5}) begin bad++;
      $display("FAIL prio_first got=%0b/%0d/%0d want=1/4/5", req_valid, req_id, req_prio); end
    take = 1'b1; step(); take = 1'b0;
    total++; if (irq_clear !== 8'h10) begin bad++; $display("FAIL prio_clear4 got=%h want=10", irq_clear); end
    done = 1'b1; step(); done = 1'b0;
    step();
    total++; if ({req_valid, req_id, req_prio} !== {1'b1, 3'd1, 3'd2}) begin bad++;
      $display("FAIL prio_tie got=%0b/%0d/%0d want=1/1/2", req_valid, req_id, req_prio); end
    take = 1'b1; step(); take = 1'b0;
    done = 1'b1; step(); done = 1'b0;
    step();
    total++; if ({req_valid, req_id, req_prio} !== {1'b1, 3'd5, 3'd2}) begin bad++;
      $display("FAIL prio_last got=%0b/%0d/%0d want=1/5/2", req_valid, req_id, req_prio); end
  endtask

  task automatic test_preempt();
    do_reset();
    cfg(0, 1'b1, 2); cfg(3, 1'b1, 4);
    irq_in[0] = 1'b1;
    step(3);
    take = 1'b1; step(); take = 1'b0;
    total++; if (run_prio !== 3'd2) begin bad++; $display("FAIL pre_run0 got=%0d want=2", run_prio); end
    irq_in[3] = 1'b1;
    step(3);
    total++; if ({req_valid, req_id, req_prio} !== {1'b1, 3'd3, 3'd4}) begin bad++;
      $display("FAIL pre_offer got=%0b/%0d/%0d want=1/3/4", req_valid, req_id, req_prio); end
    take = 1'b1; step(); take = 1'b0;
    total++; if (run_prio !== 3'd4) begin bad++; $display("FAIL pre_run3 got=%0d want=4", run_prio); end
    done = 1'b1; step();
    total++; if (run_prio !== 3'd2) begin bad++; $display("FAIL pre_pop1 got=%0d want=2", run_prio); end
    step(); done = 1'b0;
    total++; if (run_prio !== 3'd0) begin bad++; $display("FAIL pre_pop2 got=%0d want=0", run_prio); end
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 1; k <= 4; k++) cfg(k, 1'b1, k);
    cfg(6, 1'b1, 6);
    for (int k = 1; k <= 4; k++) begin
      irq_in[k] = 1'b1;
      step(3);
      total++; if ({req_valid, req_id} !== {1'b1, 3'(k)}) begin bad++;
        $display("FAIL full_nest%0d got=%0b/%0d want=1/%0d", k, req_valid, req_id, k); end
      take = 1'b1; step(); take = 1'b0;
      total++; if (run_prio !== 3'(k)) begin bad++; $display("FAIL full_run%0d got=%0d want=%0d", k, run_prio, k); end
    end
    irq_in[6] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL full_block%0d got=%0b want=0", k, req_valid); end
    end
    done = 1'b1; step(); done = 1'b0;
    total++; if (run_prio !== 3'd3) begin bad++; $display("FAIL full_pop got=%0d want=3", run_prio); end
    step();
    total++; if ({req_valid, req_id, req_prio} !== {1'b1, 3'd6, 3'd6}) begin bad++;
      $display("FAIL full_release got=%0b/%0d/%0d want=1/6/6", req_valid, req_id, req_prio); end
  endtask

  task automatic test_hold();
    do_reset();
    cfg(1, 1'b1, 3);
    // take while nothing is offered has no effect
    take = 1'b1; step(); take = 1'b0;
    total++; if ({run_prio, irq_clear} !== {3'd0, 8'h00}) begin bad++;
      $display("FAIL hold_idle_take got=%0d/%h want=0/00", run_prio, irq_clear); end
    irq_in[1] = 1'b1;
    step(3);
    take = 1'b1; step(); take = 1'b0;
    total++; if (irq_clear !== 8'h02) begin bad++; $display("FAIL hold_clear got=%h want=02", irq_clear); end
    done = 1'b1; step(); done = 1'b0;
    step(3);
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL hold_reoffer got=%0b want=0", req_valid); end
    irq_in[1] = 1'b0; step();
    irq_in[1] = 1'b1; step(3);
    total++; if ({req_valid, req_id} !== {1'b1, 3'd1}) begin bad++;
      $display("FAIL hold_reraise got=%0b/%0d want=1/1", req_valid, req_id); end
  endtask

  task automatic test_set_wins();
    do_reset();
    cfg(1, 1'b1, 3);
    irq_in[1] = 1'b1; step();
    irq_in[1] = 1'b0; step();
    irq_in[1] = 1'b1; step();
    total++; if ({req_valid, req_id} !== {1'b1, 3'd1}) begin bad++;
      $display("FAIL setwin_offer got=%0b/%0d want=1/1", req_valid, req_id); end
    take = 1'b1; step(); take = 1'b0;
    total++; if (irq_clear !== 8'h02) begin bad++; $display("FAIL setwin_clear got=%h want=02", irq_clear); end
    done = 1'b1; step(); done = 1'b0;
    step();
    total++; if ({req_valid, req_id} !== {1'b1, 3'd1}) begin bad++;
      $display("FAIL setwin_pending got=%0b/%0d want=1/1", req_valid, req_id); end
  endtask

  task automatic test_take_done();
    do_reset();
    cfg(2, 1'b1, 3);
    irq_in[2] = 1'b1;
    step(3);
    take = 1'b1; done = 1'b1; step(); take = 1'b0; done = 1'b0;
    total++; if ({run_prio, irq_clear} !== {3'd3, 8'h04}) begin bad++;
      $display("FAIL td_both got=%0d/%h want=3/04", run_prio, irq_clear); end
    // depth stayed 0, so a following done has nothing to pop
    done = 1'b1; step(); done = 1'b0;
    total++; if (run_prio !== 3'd3) begin bad++; $display("FAIL td_depth got=%0d want=3", run_prio); end
  endtask

  task automatic test_disable();
    do_reset();
    cfg(2, 1'b0, 3); cfg(6, 1'b1, 5);
    irq_in[2] = 1'b1;
    step(4);
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL dis_masked got=%0b want=0", req_valid); end
    cfg(2, 1'b1, 3);
    step();
    total++; if ({req_valid, req_id} !== {1'b1, 3'd2}) begin bad++;
      $display("FAIL dis_reenable got=%0b/%0d want=1/2", req_valid, req_id); end
    irq_in[6] = 1'b1;
    step(3);
    total++; if ({req_valid, req_id, req_prio} !== {1'b1, 3'd6, 3'd5}) begin bad++;
      $display("FAIL dis_replace got=%0b/%0d/%0d want=1/6/5", req_valid, req_id, req_prio); end
  endtask

  task automatic test_reset_nested();
    do_reset();
    cfg(1, 1'b1, 1); cfg(2, 1'b1, 2);
    irq_in[1] = 1'b1; step(3);
    take = 1'b1; step(); take = 1'b0;
    irq_in[2] = 1'b1; step(3);
    take = 1'b1; step(); take = 1'b0;
    total++; if (run_prio !== 3'd2) begin bad++; $display("FAIL rn_nested got=%0d want=2", run_prio); end
    irq_in = '0;
    reset = 1'b1; step(); reset = 1'b0;
    total++; if ({run_prio, req_valid} !== {3'd0, 1'b0}) begin bad++;
      $display("FAIL rn_after got=%0d/%0b want=0/0", run_prio, req_valid); end
    irq_in[2] = 1'b1;
    step(4);
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rn_enables got=%0b want=0", req_valid); end
    done = 1'b1; step(); done = 1'b0;
    total++; if (run_prio !== 3'd0) begin bad++; $display("FAIL rn_stack got=%0d want=0", run_prio); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_preempt();
    test_full();
    test_hold();
    test_set_wins();
    test_take_done();
    test_disable();
    test_reset_nested();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have parameter NumIrq, default 8, giving the number of interrupt sources.
REQ-002 The block SHALL have parameter PrioWidth, default 3, giving the priority field width.
REQ-003 The block SHALL have parameter StackDepth, default 4, giving the maximum nesting depth.
REQ-004 clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-005 irq_in  in  NumIrq  level interrupt lines from peripherals, e.g. the timer interrupt_set.
REQ-006 irq_clear  out  NumIrq  one-cycle pulse to the taken source, e.g. the timer interrupt_clear.
REQ-007 cfg_we  in  1  configuration write strobe.
REQ-008 cfg_idx  in  clog2(NumIrq)  index of the source being configured.
REQ-009 cfg_enable  in  1  enable bit for the indexed source.
REQ-010 cfg_prio  in  PrioWidth  priority for the indexed source; 0 means never requests.
REQ-011 req_valid  out  1  an interrupt is offered to the core.
REQ-012 req_id  out  clog2(NumIrq)  id of the offered interrupt.
REQ-013 req_prio  out  PrioWidth  priority of the offered interrupt.
REQ-014 take  in  1  core accepts the offer; effective only when req_valid=1.
REQ-015 done  in  1  core returns from the current handler.
REQ-016 run_prio  out  PrioWidth  priority currently executing; 0 means thread level.

Function
REQ-017 The block SHALL register irq_in each cycle and set pending[i] on a 0->1 transition of irq_in[i], regardless of enable[i].
REQ-018 A cfg_we write SHALL update enable[cfg_idx] and prio[cfg_idx] at the next edge, and the new values SHALL be used by arbitration from that edge on.
REQ-019 A source SHALL be eligible when pending=1, enable=1, prio!=0 and prio>run_prio (strictly greater).
REQ-020 Arbitration SHALL select the eligible source with the highest prio, breaking ties in favour of the lowest index.
REQ-021 req_valid, req_id and req_prio SHALL be registered outputs reflecting the previous cycle's arbitration.
REQ-022 Offer latency SHALL be 2 cycles: edge sampled at cycle N, pending set at N+1, req_valid=1 at N+2.
REQ-023 req_valid SHALL be 0 whenever the stack holds StackDepth entries.
REQ-024 On take with req_valid=1 the block SHALL, at the next edge:
 - push run_prio onto the stack;
 - set run_prio=req_prio;
 - clear pending[req_id];
 - pulse irq_clear[req_id] for exactly one cycle.
REQ-025 The cycle after a take SHALL force req_valid=0, so no back-to-back offer occurs.
REQ-026 take with req_valid=0 SHALL be ignored.
REQ-027 On done with a non-empty stack, run_prio SHALL be popped from the top of the stack.
REQ-028 done with an empty stack SHALL be ignored, with run_prio remaining 0.
REQ-029 take and done in the same cycle SHALL set run_prio=req_prio with the stack depth unchanged, and SHALL still clear pending and pulse irq_clear.
REQ-030 If a new rising edge on irq_in[i] coincides with take of id i, pending[i] SHALL end at 1 (set wins).
REQ-031 Disabling a pending source SHALL keep pending set; the source SHALL be offered again once re-enabled.
REQ-032 The offer SHALL be re-evaluated every cycle, so a higher-priority pending source replaces the current offer before take.

Reset
REQ-033 While reset=1 the block SHALL clear pending, enable, prio, the stack, the stack depth and the irq_in sample register.
REQ-034 Output reset values SHALL be req_valid=0, req_id=0, req_prio=0, run_prio=0 and irq_clear=0.
REQ-035 Reset asserted while a handler is nested SHALL discard all stack state at the next edge.

Verification
REQ-036 Enable irq 2 with prio 3 and raise irq_in[2] at cycle 10 -> req_valid=1, req_id=2, req_prio=3 at cycle 12; take at cycle 12 -> run_prio=3 and irq_clear[2]=1 at cycle 13.
REQ-037 Raise irq 1 (prio 2) and irq 5 (prio 2) together with irq 4 (prio 5) -> irq 4 is offered first; after take and done, irq 1 is offered before irq 5.
REQ-038 With irq 0 (prio 2) running, raise irq 3 (prio 4) -> preemption offer occurs with run_prio stack [0,2]; done, done -> run_prio returns to 2, then 0.
REQ-039 With StackDepth=4, nest 4 takes at prios 1,2,3,4, then raise prio 6 -> req_valid stays 0 until one done.
REQ-040 Hold irq_in[1] high across its take -> no re-offer; drop and re-raise -> offered again.
REQ-041 Assert reset with depth=2 -> run_prio=0, req_valid=0, all enables=0 after one edge.
